// File: rtl/out_spike_packetizer.sv
// Double-buffered spike collector that serialises one timestep's fired neurons into NoC packets.
// Define PKT_TIMESTAMP_EN to prepend a per-timestep timestamp field to every packet.
module out_spike_packetizer #(
  parameter int NUM_NEURONS          = 256,
  parameter int NEURON_CNT_BIT_WIDTH = 8,
  parameter int COORD_WIDTH          = 4,
  parameter int X_ID                 = 1,
  parameter int Y_ID                 = 1,
  parameter int TS_WIDTH             = 8,
`ifdef PKT_TIMESTAMP_EN
  localparam int PKT_WIDTH = TS_WIDTH + 2*COORD_WIDTH + NEURON_CNT_BIT_WIDTH
`else
  localparam int PKT_WIDTH = 2*COORD_WIDTH + NEURON_CNT_BIT_WIDTH
`endif
) (
  input  logic                            clk_i,
  input  logic                            rst_n_i,
  input  logic                            start_i,
  input  logic                            wrEn_spike_i,
  input  logic [NEURON_CNT_BIT_WIDTH-1:0] neuronAddr_i,
  input  logic                            spike_i,
  output logic [PKT_WIDTH-1:0]            pkt_o,
  output logic                            pkt_valid_o,
  input  logic                            pkt_ready_i,
  output logic                            busy_o,
  output logic                            done_o,
  output logic [NEURON_CNT_BIT_WIDTH:0]   spikeCnt_o,
  output logic                            overrun_o
);

  localparam logic [NEURON_CNT_BIT_WIDTH-1:0] LAST_IDX = NEURON_CNT_BIT_WIDTH'(NUM_NEURONS - 1);
  localparam logic [COORD_WIDTH-1:0]          X_COORD  = COORD_WIDTH'(X_ID);
  localparam logic [COORD_WIDTH-1:0]          Y_COORD  = COORD_WIDTH'(Y_ID);

  if (NEURON_CNT_BIT_WIDTH < $clog2(NUM_NEURONS) || TS_WIDTH < 1) begin : g_param_check
    $error("out_spike_packetizer: NEURON_CNT_BIT_WIDTH too small or TS_WIDTH < 1");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_SEND,
    ST_DONE
  } state_t;

  state_t                          state_q, state_d;
  logic [NEURON_CNT_BIT_WIDTH-1:0] idx_q, idx_d;
  logic [PKT_WIDTH-1:0]            pkt_q, pkt_d;
  logic [NEURON_CNT_BIT_WIDTH:0]   cnt_q, cnt_d;
  logic                            overrun_q, overrun_d;
  logic [NUM_NEURONS-1:0]          collect_q, collect_d;
  logic [NUM_NEURONS-1:0]          send_q, send_d;
  logic                            start_accept;
`ifdef PKT_TIMESTAMP_EN
  logic [TS_WIDTH-1:0]             ts_q, ts_d;
  logic [TS_WIDTH-1:0]             pass_ts_q, pass_ts_d;
`endif

  assign start_accept = start_i && (state_q == ST_IDLE);

  // A start clears the collect buffer first, so a coincident write belongs to the new timestep.
  always_comb begin
    collect_d = start_accept ? '0 : collect_q;
    if (wrEn_spike_i && spike_i) begin
      for (int i = 0; i < NUM_NEURONS; i++) begin
        if (neuronAddr_i == NEURON_CNT_BIT_WIDTH'(i)) begin
          collect_d[i] = 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    pkt_d     = pkt_q;
    cnt_d     = cnt_q;
    send_d    = send_q;
    overrun_d = overrun_q;
`ifdef PKT_TIMESTAMP_EN
    ts_d      = ts_q;
    pass_ts_d = pass_ts_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start_i) begin
          send_d  = collect_q;
          cnt_d   = '0;
          idx_d   = '0;
          state_d = ST_SCAN;
`ifdef PKT_TIMESTAMP_EN
          pass_ts_d = ts_q;
          ts_d      = ts_q + 1'b1;
`endif
        end
      end
      ST_SCAN: begin
        if (send_q[idx_q]) begin
`ifdef PKT_TIMESTAMP_EN
          pkt_d = {pass_ts_q, X_COORD, Y_COORD, idx_q};
`else
          pkt_d = {X_COORD, Y_COORD, idx_q};
`endif
          state_d = ST_SEND;
        end else if (idx_q == LAST_IDX) begin
          state_d = ST_DONE;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      ST_SEND: begin
        if (pkt_ready_i) begin
          cnt_d         = cnt_q + 1'b1;
          send_d[idx_q] = 1'b0;
          if (idx_q == LAST_IDX) begin
            state_d = ST_DONE;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = ST_SCAN;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // A start outside IDLE is dropped; the sticky flag records that a timestep was merged.
    if (start_i && (state_q != ST_IDLE)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q   <= ST_IDLE;
      idx_q     <= '0;
      pkt_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
      collect_q <= '0;
      send_q    <= '0;
`ifdef PKT_TIMESTAMP_EN
      ts_q      <= '0;
      pass_ts_q <= '0;
`endif
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      pkt_q     <= pkt_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
      collect_q <= collect_d;
      send_q    <= send_d;
`ifdef PKT_TIMESTAMP_EN
      ts_q      <= ts_d;
      pass_ts_q <= pass_ts_d;
`endif
    end
  end

  assign pkt_o       = pkt_q;
  assign pkt_valid_o = (state_q == ST_SEND);
  assign busy_o      = (state_q != ST_IDLE);
  assign done_o      = (state_q == ST_DONE);
  assign spikeCnt_o  = cnt_q;
  assign overrun_o   = overrun_q;

endmodule

// File: tb/tb_out_spike_packetizer.sv
// Scoreboard bench for out_spike_packetizer: expected packets queued at each start, compared per pass.
module tb_out_spike_packetizer;

  localparam int NUM_NEURONS = 256;
  localparam int NCW         = 8;
  localparam int COORD_WIDTH = 4;
  localparam int X_ID        = 1;
  localparam int Y_ID        = 1;
  localparam int TS_WIDTH    = 8;
`ifdef PKT_TIMESTAMP_EN
  localparam int PKT_WIDTH = TS_WIDTH + 2*COORD_WIDTH + NCW;
`else
  localparam int PKT_WIDTH = 2*COORD_WIDTH + NCW;
`endif
  localparam int BUDGET = 2*NUM_NEURONS + 64;

  logic                 clk = 1'b0;
  logic                 rst_n = 1'b0;
  logic                 start = 1'b0;
  logic                 wr = 1'b0;
  logic [NCW-1:0]       addr = '0;
  logic                 spike = 1'b0;
  logic [PKT_WIDTH-1:0] pkt;
  logic                 valid;
  logic                 ready = 1'b1;
  logic                 busy;
  logic                 done;
  logic [NCW:0]         cnt;
  logic                 overrun;

  int tests_run = 0;
  int tests_failed = 0;
  int cycle = 0;

  logic [PKT_WIDTH-1:0]   exp_q[$];
  logic [PKT_WIDTH-1:0]   obs_q[$];
  logic [NUM_NEURONS-1:0] model_collect = '0;
  int                     model_ts = 0;
  int                     t_start, done_cycle, stall_cycles, stable_errs, exp_n;
  bit                     timed_out;

  out_spike_packetizer #(
    .NUM_NEURONS(NUM_NEURONS), .NEURON_CNT_BIT_WIDTH(NCW), .COORD_WIDTH(COORD_WIDTH),
    .X_ID(X_ID), .Y_ID(Y_ID), .TS_WIDTH(TS_WIDTH)
  ) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .wrEn_spike_i(wr),
    .neuronAddr_i(addr), .spike_i(spike), .pkt_o(pkt), .pkt_valid_o(valid),
    .pkt_ready_i(ready), .busy_o(busy), .done_o(done), .spikeCnt_o(cnt),
    .overrun_o(overrun)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic write_spike(input int a, input logic s);
    wr = 1'b1; addr = NCW'(a); spike = s;
    tick();
    wr = 1'b0; spike = 1'b0;
    if (s) model_collect[a] = 1'b1;
  endtask

  // Pulses start from IDLE and pushes the packets the pass must produce, in index order.
  task automatic pulse_start(input bit with_wr, input int a);
    logic [PKT_WIDTH-1:0] p;
    start = 1'b1; wr = with_wr; addr = NCW'(a); spike = with_wr;
    tick();
    start = 1'b0; wr = 1'b0; spike = 1'b0;
    t_start = cycle;
    exp_n = 0;
    for (int i = 0; i < NUM_NEURONS; i++) begin
      if (model_collect[i]) begin
`ifdef PKT_TIMESTAMP_EN
        p = {TS_WIDTH'(model_ts), COORD_WIDTH'(X_ID), COORD_WIDTH'(Y_ID), NCW'(i)};
`else
        p = {COORD_WIDTH'(X_ID), COORD_WIDTH'(Y_ID), NCW'(i)};
`endif
        exp_q.push_back(p);
        exp_n++;
      end
    end
    model_collect = '0;
    model_ts = (model_ts + 1) % (1 << TS_WIDTH);
    if (with_wr) model_collect[a] = 1'b1;
  endtask

  // Runs one pass to DONE, recording accepted packets, stalls, and valid/pkt stability breaks.
  task automatic capture_pass(input int hold, input int inject_at);
    logic                 prev_valid, prev_acc;
    logic [PKT_WIDTH-1:0] prev_pkt;
    obs_q.delete();
    done_cycle = -1; stall_cycles = 0; stable_errs = 0; timed_out = 1'b1;
    prev_valid = 1'b0; prev_acc = 1'b0; prev_pkt = '0;
    for (int k = 0; k < BUDGET; k++) begin
      start = 1'b0; wr = 1'b0; spike = 1'b0;
      if (k == inject_at) begin
        start = 1'b1; wr = 1'b1; addr = NCW'(40); spike = 1'b1;
        model_collect[40] = 1'b1;
      end
      if (valid && hold > 0) begin
        ready = 1'b0; hold--; stall_cycles++;
      end else begin
        ready = 1'b1;
      end
      if (prev_valid && !prev_acc && (!valid || pkt !== prev_pkt)) stable_errs++;
      if (valid && ready) obs_q.push_back(pkt);
      prev_valid = valid; prev_acc = valid && ready; prev_pkt = pkt;
      if (done) begin
        done_cycle = cycle + 1;
        timed_out = 1'b0;
      end
      tick();
      if (!timed_out) break;
    end
    start = 1'b0; wr = 1'b0; spike = 1'b0; ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    tick(); tick();
    tests_run++; if (pkt !== '0)      begin tests_failed++; $display("[TB] FAIL reset_pkt: got %h expected 0", pkt); end
    tests_run++; if (valid !== 1'b0)  begin tests_failed++; $display("[TB] FAIL reset_valid: got %b expected 0", valid); end
    tests_run++; if (busy !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
    tests_run++; if (done !== 1'b0)   begin tests_failed++; $display("[TB] FAIL reset_done: got %b expected 0", done); end
    tests_run++; if (cnt !== '0)      begin tests_failed++; $display("[TB] FAIL reset_cnt: got %0d expected 0", cnt); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL reset_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    logic [PKT_WIDTH-1:0] e;
    write_spike(3, 1'b1);
    write_spike(17, 1'b1);
    write_spike(17, 1'b0);
    write_spike(100, 1'b0);
    write_spike(255, 1'b1);
    pulse_start(1'b0, 0);
    capture_pass(0, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("[TB] FAIL basic_timeout: no done within %0d cycles", BUDGET); end
    tests_run++; if (obs_q.size() != exp_n) begin tests_failed++; $display("[TB] FAIL basic_npkts: got %0d expected %0d", obs_q.size(), exp_n); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[i] !== e) begin tests_failed++; $display("[TB] FAIL basic_pkt%0d: got %h expected %h", i, obs_q[i], e); end
    end
    exp_q.delete();
    tests_run++; if (done_cycle - t_start != NUM_NEURONS + 4) begin tests_failed++; $display("[TB] FAIL basic_done_time: got %0d expected %0d", done_cycle - t_start, NUM_NEURONS + 4); end
    tick(); tick(); tick();
    tests_run++; if (cnt !== 9'd3) begin tests_failed++; $display("[TB] FAIL basic_cnt_hold: got %0d expected 3", cnt); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL basic_busy_after: got %b expected 0", busy); end
  endtask

  task automatic test_empty();
    pulse_start(1'b0, 0);
    capture_pass(0, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("[TB] FAIL empty_timeout: no done within %0d cycles", BUDGET); end
    tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL empty_npkts: got %0d expected 0", obs_q.size()); end
    tests_run++; if (done_cycle - t_start != NUM_NEURONS + 1) begin tests_failed++; $display("[TB] FAIL empty_done_time: got %0d expected %0d", done_cycle - t_start, NUM_NEURONS + 1); end
    tests_run++; if (cnt !== 9'd0) begin tests_failed++; $display("[TB] FAIL empty_cnt: got %0d expected 0", cnt); end
    exp_q.delete();
  endtask

  task automatic test_backpressure();
    logic [PKT_WIDTH-1:0] e;
    write_spike(5, 1'b1);
    pulse_start(1'b0, 0);
    capture_pass(10, -1);
    tests_run++; if (timed_out) begin tests_failed++; $display("[TB] FAIL bp_timeout: no done within %0d cycles", BUDGET); end
    tests_run++; if (stall_cycles != 10) begin tests_failed++; $display("[TB] FAIL bp_stalls: got %0d expected 10", stall_cycles); end
    tests_run++; if (stable_errs != 0) begin tests_failed++; $display("[TB] FAIL bp_stable: got %0d breaks expected 0", stable_errs); end
    tests_run++; if (obs_q.size() != exp_n) begin tests_failed++; $display("[TB] FAIL bp_npkts: got %0d expected %0d", obs_q.size(), exp_n); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[i] !== e) begin tests_failed++; $display("[TB] FAIL bp_pkt%0d: got %h expected %h", i, obs_q[i], e); end
    end
    exp_q.delete();
    tests_run++; if (cnt !== 9'd1) begin tests_failed++; $display("[TB] FAIL bp_cnt: got %0d expected 1", cnt); end
  endtask

  task automatic test_same_cycle_write();
    logic [PKT_WIDTH-1:0] e;
    write_spike(9, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start(pass == 0, 9);
      capture_pass(0, -1);
      tests_run++; if (obs_q.size() != exp_n || exp_n != 1) begin tests_failed++; $display("[TB] FAIL same_npkts%0d: got %0d expected %0d", pass, obs_q.size(), exp_n); end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        tests_run++; if (obs_q[i] !== e) begin tests_failed++; $display("[TB] FAIL same_pkt%0d: got %h expected %h", pass, obs_q[i], e); end
      end
      exp_q.delete();
    end
  endtask

  task automatic test_overrun();
    logic [PKT_WIDTH-1:0] e;
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL ovr_before: got %b expected 0", overrun); end
    write_spike(10, 1'b1);
    write_spike(20, 1'b1);
    for (int pass = 0; pass < 2; pass++) begin
      pulse_start(1'b0, 0);
      capture_pass(0, pass == 0 ? 20 : -1);
      tests_run++; if (obs_q.size() != exp_n) begin tests_failed++; $display("[TB] FAIL ovr_npkts%0d: got %0d expected %0d", pass, obs_q.size(), exp_n); end
      for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
        e = exp_q.pop_front();
        tests_run++; if (obs_q[i] !== e) begin tests_failed++; $display("[TB] FAIL ovr_pkt%0d_%0d: got %h expected %h", pass, i, obs_q[i], e); end
      end
      exp_q.delete();
      tests_run++; if (overrun !== 1'b1) begin tests_failed++; $display("[TB] FAIL ovr_flag%0d: got %b expected 1", pass, overrun); end
    end
  endtask

  task automatic test_reset_mid_send();
    logic [PKT_WIDTH-1:0] e;
    bit seen;
    write_spike(7, 1'b1);
    pulse_start(1'b0, 0);
    ready = 1'b0;
    seen = 1'b0;
    for (int k = 0; k < 32 && !seen; k++) begin
      if (valid) seen = 1'b1;
      else tick();
    end
    tests_run++; if (!seen) begin tests_failed++; $display("[TB] FAIL rst_valid_seen: got 0 expected 1"); end
    rst_n = 1'b0;
    tick();
    tests_run++; if (valid !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_valid_drop: got %b expected 0", valid); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
    tests_run++; if (overrun !== 1'b0) begin tests_failed++; $display("[TB] FAIL rst_overrun: got %b expected 0", overrun); end
    rst_n = 1'b1;
    ready = 1'b1;
    tick();
    exp_q.delete();
    model_collect = '0;
    model_ts = 0;
    pulse_start(1'b0, 0);
    capture_pass(0, -1);
    tests_run++; if (obs_q.size() != 0) begin tests_failed++; $display("[TB] FAIL rst_empty_npkts: got %0d expected 0", obs_q.size()); end
    exp_q.delete();
    write_spike(2, 1'b1);
    pulse_start(1'b0, 0);
    capture_pass(0, -1);
    tests_run++; if (obs_q.size() != 1) begin tests_failed++; $display("[TB] FAIL rst_ts_npkts: got %0d expected 1", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && exp_q.size() > 0; i++) begin
      e = exp_q.pop_front();
      tests_run++; if (obs_q[i] !== e) begin tests_failed++; $display("[TB] FAIL rst_ts_pkt: got %h expected %h", obs_q[i], e); end
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_basic();
    test_empty();
    test_backpressure();
    test_same_cycle_write();
    test_overrun();
    test_reset_mid_send();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/out_spike_packetizer.md
# out_spike_packetizer

Output-side counterpart of the core's input spike buffer. It collects per-neuron fire events from the neuron update pipeline during a timestep. At the timestep boundary it snapshots them and serialises every fired neuron into one packet toward the local NoC router port, using a valid/ready handshake. A double buffer lets collection for timestep k+1 proceed while timestep k is being sent.

## Interface
Parameters:
- NUM_NEURONS, 256, neurons in the core; number of buffer bits
- NEURON_CNT_BIT_WIDTH, 8, neuron index width; must be ≥ ceil(log2(NUM_NEURONS))
- COORD_WIDTH, 4, width of each router coordinate field
- X_ID, 1, this core's X coordinate (numeric, COORD_WIDTH bits)
- Y_ID, 1, this core's Y coordinate (numeric, COORD_WIDTH bits)
- TS_WIDTH, 8, timestamp field width; used only with PKT_TIMESTAMP_EN

Ports:
- clk_i  in  1  single clock, rising edge
- rst_n_i  in  1  synchronous, active-low reset
- start_i  in  1  one-cycle timestep-boundary pulse
- wrEn_spike_i  in  1  neuron result write strobe
- neuronAddr_i  in  NEURON_CNT_BIT_WIDTH  neuron index of the write
- spike_i  in  1  1 = neuron fired
- pkt_o  out  PKT_WIDTH  packet {X_ID, Y_ID, neuron index} (MSB→LSB); with the macro, {timestamp, X_ID, Y_ID, index}
- pkt_valid_o  out  1  packet valid
- pkt_ready_i  in  1  router accepts the packet
- busy_o  out  1  send in progress
- done_o  out  1  one-cycle pulse when the send pass completes
- spikeCnt_o  out  NEURON_CNT_BIT_WIDTH+1  packets accepted in the last or current pass
- overrun_o  out  1  sticky: start_i arrived while busy

## Operation
- CollectBuf[NUM_NEURONS]: on wrEn_spike_i, bit neuronAddr_i is ORed with spike_i, so a later 0 never clears a fired bit. Addresses ≥ NUM_NEURONS are ignored.
- Accepted start_i (FSM in IDLE):
  - SendBuf ← CollectBuf; CollectBuf cleared.
  - spikeCnt_o ← 0; scan index ← 0; go to SCAN.
- If wrEn_spike_i coincides with an accepted start_i, the write lands in the freshly cleared CollectBuf and belongs to the next timestep.
- start_i while busy:
  - Ignored for swapping; overrun_o set (cleared only by reset).
  - CollectBuf keeps accumulating and is swapped at the next accepted start_i.
- FSM:
  - IDLE: wait for start_i.
  - SCAN: examines SendBuf[idx], one index per cycle.
    - Bit set: register pkt_o and go to SEND.
    - Bit clear and idx = NUM_NEURONS-1: go to DONE.
    - Otherwise: idx+1.
  - SEND: pkt_valid_o = 1, pkt_o stable until pkt_valid_o & pkt_ready_i.
    - On accept: spikeCnt_o+1, clear SendBuf[idx].
    - Then go to DONE if idx = NUM_NEURONS-1, else idx+1 and go to SCAN.
  - DONE: done_o = 1 for one cycle, then IDLE.
- busy_o = 1 in SCAN, SEND and DONE.
- Packets are emitted in ascending neuron index, with no duplicates.
- The index does not wrap; a pass always terminates at NUM_NEURONS-1.

## Timing
- Reset: pkt_o = 0, pkt_valid_o = 0, busy_o = 0, done_o = 0, spikeCnt_o = 0, overrun_o = 0. Both buffers cleared, FSM IDLE, timestamp 0.
- Reset asserted mid-pass abandons any in-flight packet. pkt_valid_o drops on the next edge, which is the only permitted valid drop without accept.
- start_i sampled at edge t → busy_o high after t. Index 0 is examined in cycle t+1. If neuron 0 fired, pkt_valid_o is high after edge t+1.
- Each packet costs 1 SCAN cycle plus ≥1 SEND cycle. Each silent neuron costs 1 cycle.
- Pass length with ready tied high: NUM_NEURONS + nSpikes + 1 (DONE) cycles.
- pkt_ready_i may be high before valid. Only the cycle with both high transfers.
- spikeCnt_o updates on the accept edge and holds its value after DONE until the next accepted start_i.

## Configuration
- PKT_TIMESTAMP_EN defined:
  - PKT_WIDTH = TS_WIDTH + 2*COORD_WIDTH + NEURON_CNT_BIT_WIDTH.
  - A TS_WIDTH counter increments on each accepted start_i and wraps modulo 2^TS_WIDTH.
  - The first pass after reset carries timestamp 0.
- PKT_TIMESTAMP_EN undefined: PKT_WIDTH = 2*COORD_WIDTH + NEURON_CNT_BIT_WIDTH; no counter logic.

## Test plan
- Reset, write spikes to neurons 3, 17 and 255, pulse start_i, ready high → packets with index 3, 17, 255 in order. spikeCnt_o = 3; done_o pulses at cycle t+NUM_NEURONS+4.
- No writes, start_i → zero packets, done_o after NUM_NEURONS+1 cycles, spikeCnt_o = 0.
- Spike on neuron 5, ready low for 10 cycles → pkt_o/pkt_valid_o held stable for 10 cycles; one transfer when ready rises.
- Write neuron 9 in the same cycle as start_i, and neuron 9 fired in the prior timestep → index 9 sent in this pass and again in the next pass.
- start_i during a pass with 2 spikes → overrun_o = 1, current pass completes unchanged; spikes written meanwhile are sent after the next start_i.
- Reset mid-SEND with ready low → pkt_valid_o = 0 next cycle; a subsequent start_i with no writes emits nothing. With PKT_TIMESTAMP_EN, the timestamp field reads 0 on the first pass after reset and 1 on the second.
